reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter MAX_CYCLES, default 100, sets the run length in clock cycles (legal 1..65535).
REQ-002 Parameter NREGS, default 32, sets the number of registers dumped (legal 2..32).
REQ-003 Parameter XLEN, default 32, sets the register data width.
REQ-004 clock  input  1  sets the single clock domain; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  is the synchronous, active-low reset, sampled on the rising edge of clock.
REQ-006 start  input  1  is a one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-007 cpu_halt  output  1  freezes the CPU when high; the CPU runs only while it is low.
REQ-008 rf_raddr  output  5  is the register-file read address.
REQ-009 rf_rdata  input  XLEN  is the register-file read data, valid one cycle after rf_raddr.
REQ-010 dump_valid  output  1  indicates that dump_idx and dump_data are valid.
REQ-011 dump_ready  input  1  is the consumer's acceptance of the current dump beat.
REQ-012 dump_idx  output  5  is the register index of the current beat.
REQ-013 dump_data  output  XLEN  is the register value of the current beat.
REQ-014 done  output  1  is high while the dump is complete.
REQ-015 cycle_count  output  16  is the number of cycles the CPU has run.

Function
REQ-016 The block SHALL use the states IDLE, RUN, DRAIN, READ, LOAD, SEND and DONE.
REQ-017 IDLE: cpu_halt=1; on start=1, clear cycle_count to 0 and go to RUN.
REQ-018 RUN: cpu_halt=0; cycle_count increments by 1 each cycle.
REQ-019 RUN exit: in the cycle where cycle_count==MAX_CYCLES-1, increment cycle_count and go to DRAIN, so that exactly MAX_CYCLES cycles run with cpu_halt=0.
REQ-020 DRAIN: cpu_halt=1 for one cycle; clear the index to 0; go to READ.
REQ-021 READ: drive rf_raddr=index; go to LOAD.
REQ-022 LOAD: hold rf_raddr; register rf_rdata into dump_data and index into dump_idx; go to SEND.
REQ-023 SEND: dump_valid=1, with dump_idx and dump_data held stable until the handshake (dump_valid and dump_ready both high at a rising edge).
REQ-024 SEND on handshake with index==NREGS-1: go to DONE; otherwise increment index and go to READ.
REQ-025 SEND with dump_ready=0: remain in SEND indefinitely with no change to any output.
REQ-026 dump_valid SHALL be high only in SEND and SHALL never depend combinationally on dump_ready.
REQ-027 Each register takes a minimum of 3 cycles (READ, LOAD, SEND); a full dump with dump_ready held high takes 3*NREGS cycles.
REQ-028 DONE: done=1 and cpu_halt=1; on start=1, clear cycle_count, deassert done and go to RUN.
REQ-029 start SHALL be ignored in RUN, DRAIN, READ, LOAD and SEND.
REQ-030 cycle_count SHALL hold its value outside RUN and DRAIN and SHALL never wrap.
REQ-031 Register 0 SHALL be read and dumped like any other register; the block SHALL not substitute a value for it.

Reset
REQ-032 When reset_n=0 at a rising edge, the block SHALL enter IDLE with cpu_halt=1, dump_valid=0, done=0, cycle_count=0, rf_raddr=0, dump_idx=0 and dump_data=0.
REQ-033 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-034 Reset asserted in any state, including mid-dump with dump_valid=1, SHALL abort the operation without completing the beat.

Verification
REQ-035 Scenario: reset, then start pulse, MAX_CYCLES=100 -> cpu_halt low for exactly 100 cycles, cycle_count=100, then DRAIN.
REQ-036 Scenario: register file preloaded with reg[i]=i*3 and dump_ready tied high -> 32 beats, idx 0..31, data 0..93, done rises 96 cycles after DRAIN.
REQ-037 Scenario: dump_ready low for 5 cycles during beat 7 -> dump_idx=7 and dump_data=21 held stable for those cycles; no beat lost or duplicated.
REQ-038 Scenario: start pulsed during RUN and during SEND -> ignored; cycle_count and the beat sequence are unaffected.
REQ-039 Scenario: reset_n low at beat 12 in SEND -> next cycle IDLE, dump_valid=0, cycle_count=0; a fresh start then dumps from idx 0.
REQ-040 Scenario: start pulse in DONE -> done=0 next cycle, cpu_halt=0, cycle_count restarts at 0 and counts up to 100.

Source files
------------

// File: rtl/reg_dump_unit_if.sv
// Dump channel between reg_dump_unit and its consumer: valid/ready beat
// carrying a register index and its value.
interface reg_dump_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            dump_valid;
    logic            dump_ready;
    logic [4:0]      dump_idx;
    logic [XLEN-1:0] dump_data;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/reg_dump_unit.sv
// Runs the CPU for MAX_CYCLES cycles, halts it, then streams registers
// 0..NREGS-1 out over a valid/ready channel.
module reg_dump_unit #(
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned XLEN       = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    output logic            cpu_halt,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    reg_dump_unit_if.master dump,
    output logic            done,
    output logic [15:0]     cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        READ,
        LOAD,
        SEND,
        DONE
    } state_e;

    localparam logic [15:0] LAST_CYCLE = 16'(MAX_CYCLES - 1);
    localparam logic [4:0]  LAST_REG   = 5'(NREGS - 1);

    state_e          state_q, state_d;
    logic [15:0]     cycle_q, cycle_d;
    logic [4:0]      index_q, index_d;
    logic [4:0]      idx_q,   idx_d;
    logic [XLEN-1:0] data_q,  data_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cycle_q <= '0;
            index_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            index_q <= index_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        index_d = index_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cycle_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The exit cycle still counts, so DRAIN sees cycle_count==MAX_CYCLES.
                cycle_d = cycle_q + 16'd1;
                if (cycle_q == LAST_CYCLE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                index_d = '0;
                state_d = READ;
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                data_d  = rf_rdata;
                idx_d   = index_q;
                state_d = SEND;
            end
            SEND: begin
                if (dump.dump_ready) begin
                    if (index_q == LAST_REG) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    cycle_d = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs come straight from state or registers; none depends on dump_ready.
    always_comb begin
        cpu_halt        = (state_q != RUN);
        done            = (state_q == DONE);
        dump.dump_valid = (state_q == SEND);
        dump.dump_idx   = idx_q;
        dump.dump_data  = data_q;
        rf_raddr        = index_q;
        cycle_count     = cycle_q;
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: table of full run/dump scenarios plus
// hand-written reset-abort and restart sequences.
module tb_reg_dump_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    typedef struct {
        int unsigned stall_beat;
        int unsigned stall_len;
        logic [31:0] mask;
        bit          start_in_run;
        bit          start_in_send;
        int unsigned exp_run;
        int unsigned exp_beats;
        int unsigned exp_lat;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            start;
    logic            cpu_halt;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            done;
    logic [15:0]     cycle_count;
    logic [31:0]     regs [NREGS];

    int unsigned errors = 0;
    int unsigned checks = 0;

    reg_dump_unit_if #(.XLEN(XLEN)) dif ();

    reg_dump_unit #(
        .MAX_CYCLES(100),
        .NREGS     (NREGS),
        .XLEN      (XLEN)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .cpu_halt   (cpu_halt),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dump       (dif),
        .done       (done),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // Register file model: synchronous read, data valid one cycle after address.
    always @(posedge clock) begin
        rf_rdata <= regs[rf_raddr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_val(input int unsigned i, input logic [31:0] mask);
        return 32'(i * 3) ^ mask;
    endfunction

    task automatic load_rf(input logic [31:0] mask);
        for (int i = 0; i < NREGS; i++) begin
            regs[i] = rf_val(i, mask);
        end
    endtask

    task automatic run_phase(input bit poke, input int unsigned exp_run);
        int unsigned n;
        n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done_low", {31'd0, done}, 32'd0);
        check("start_count_zero", {16'd0, cycle_count}, 32'd0);
        while (!cpu_halt && n < 1000) begin
            start = (poke && n == 50);
            n++;
            tick();
        end
        start = 1'b0;
        check("run_len", n, exp_run);
        check("drain_count", {16'd0, cycle_count}, exp_run);
    endtask

    task automatic dump_phase(input vec_t v);
        int unsigned beat;
        int unsigned stalled;
        int unsigned lat;
        beat    = 0;
        stalled = 0;
        lat     = 0;
        dif.dump_ready = 1'b1;
        while (!done && lat < 500) begin
            tick();
            lat++;
            start = 1'b0;
            if (dif.dump_valid) begin
                check("beat_idx", {27'd0, dif.dump_idx}, {27'd0, 5'(beat)});
                check("beat_data", dif.dump_data, rf_val(beat, v.mask));
                if (v.stall_len != 0 && beat == v.stall_beat && stalled < v.stall_len) begin
                    dif.dump_ready = 1'b0;
                    stalled++;
                end else begin
                    dif.dump_ready = 1'b1;
                    beat++;
                end
                if (v.start_in_send && beat == 20) begin
                    start = 1'b1;
                end
            end
        end
        start = 1'b0;
        dif.dump_ready = 1'b1;
        check("beat_total", beat, v.exp_beats);
        check("done_latency", lat, v.exp_lat);
        check("done_flag", {31'd0, done}, 32'd1);
        check("done_halt", {31'd0, cpu_halt}, 32'd1);
        check("done_valid_low", {31'd0, dif.dump_valid}, 32'd0);
        check("done_count", {16'd0, cycle_count}, v.exp_run);
    endtask

    initial begin
        vec_t vecs [3];
        int unsigned lat;

        // Latency counts from the DRAIN sample: 3 per register + DRAIN + stall cycles.
        vecs[0] = '{stall_beat: 0, stall_len: 0, mask: 32'h0000_0000,
                    start_in_run: 1'b0, start_in_send: 1'b0,
                    exp_run: 100, exp_beats: 32, exp_lat: 97};
        vecs[1] = '{stall_beat: 7, stall_len: 5, mask: 32'h0000_0000,
                    start_in_run: 1'b0, start_in_send: 1'b0,
                    exp_run: 100, exp_beats: 32, exp_lat: 102};
        vecs[2] = '{stall_beat: 0, stall_len: 0, mask: 32'hA5A5_0000,
                    start_in_run: 1'b1, start_in_send: 1'b1,
                    exp_run: 100, exp_beats: 32, exp_lat: 97};

        reset_n        = 1'b0;
        start          = 1'b0;
        dif.dump_ready = 1'b1;
        load_rf(32'h0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_halt", {31'd0, cpu_halt}, 32'd1);
        check("rst_valid", {31'd0, dif.dump_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {16'd0, cycle_count}, 32'd0);
        check("rst_raddr", {27'd0, rf_raddr}, 32'd0);
        check("rst_idx", {27'd0, dif.dump_idx}, 32'd0);
        check("rst_data", dif.dump_data, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_halt", {31'd0, cpu_halt}, 32'd1);

        // Runs after the first start from DONE, covering restart from the done state.
        for (int i = 0; i < 3; i++) begin
            load_rf(vecs[i].mask);
            run_phase(vecs[i].start_in_run, vecs[i].exp_run);
            dump_phase(vecs[i]);
        end

        // Abort mid-beat: reset wins over a handshake in the same cycle.
        load_rf(32'h0);
        run_phase(1'b0, 100);
        dif.dump_ready = 1'b1;
        lat = 0;
        while (!(dif.dump_valid && dif.dump_idx == 5'd12) && lat < 500) begin
            tick();
            lat++;
        end
        check("reached_beat12", {27'd0, dif.dump_idx}, 32'd12);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_valid", {31'd0, dif.dump_valid}, 32'd0);
        check("abort_count", {16'd0, cycle_count}, 32'd0);
        check("abort_halt", {31'd0, cpu_halt}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_idx", {27'd0, dif.dump_idx}, 32'd0);
        check("abort_data", dif.dump_data, 32'd0);
        tick();
        tick();
        check("abort_idle_halt", {31'd0, cpu_halt}, 32'd1);
        check("abort_idle_valid", {31'd0, dif.dump_valid}, 32'd0);

        load_rf(vecs[2].mask);
        run_phase(1'b0, 100);
        dump_phase(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
